// File: rtl/minhash_pkg.sv
// Shared definitions for the MinHash sketch controller: default sizes,
// controller state encoding, the empty-slot sentinel and a slot record.
package minhash_pkg;

  localparam int SIGNATURE_WIDTH_DEF = 32;
  localparam int INDEX_WIDTH_DEF     = 10;
  localparam int NUM_COMPARATORS_DEF = 8;
  localparam int LOG_COMPARATORS_DEF = 3;

  typedef enum logic [1:0] {
    ST_ACCEPT  = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_READOUT = 2'd2,
    ST_CLEAR   = 2'd3
  } state_t;

  // An empty slot holds an all-ones signature, which no real beat can displace into.
  localparam logic [SIGNATURE_WIDTH_DEF-1:0] SENTINEL_SIG = '1;

  typedef struct packed {
    logic [SIGNATURE_WIDTH_DEF-1:0] sig;
    logic [INDEX_WIDTH_DEF-1:0]     idx;
  } slot_t;

endpackage

// File: rtl/minhash_topk_store.sv
// Bottom-k store: NUM_COMPARATORS (signature, index) slots plus a
// combinational max-finder. A beat replaces the current maximum slot
// (lowest slot number on ties) when its signature is strictly smaller.
module minhash_topk_store
  import minhash_pkg::*;
#(
  parameter int SIGNATURE_WIDTH = SIGNATURE_WIDTH_DEF,
  parameter int INDEX_WIDTH     = INDEX_WIDTH_DEF,
  parameter int NUM_COMPARATORS = NUM_COMPARATORS_DEF,
  parameter int LOG_COMPARATORS = LOG_COMPARATORS_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_ins_valid,
  input  logic [SIGNATURE_WIDTH-1:0] i_ins_sig,
  input  logic [INDEX_WIDTH-1:0]     i_ins_idx,
  input  logic                       i_clear,
  input  logic [LOG_COMPARATORS-1:0] i_rd_slot,
  output logic [SIGNATURE_WIDTH-1:0] o_rd_sig,
  output logic [INDEX_WIDTH-1:0]     o_rd_idx
);

  logic [SIGNATURE_WIDTH-1:0] r_sig [NUM_COMPARATORS];
  logic [INDEX_WIDTH-1:0]     r_idx [NUM_COMPARATORS];

  logic [SIGNATURE_WIDTH-1:0] w_max_sig;
  logic [LOG_COMPARATORS-1:0] w_max_slot;
  logic                       w_do_insert;

  // Find the largest stored signature from live contents; strict '>' keeps the lowest slot on ties.
  always_comb begin
    w_max_sig  = r_sig[0];
    w_max_slot = '0;
    for (int i = 1; i < NUM_COMPARATORS; i++) begin
      if (r_sig[i] > w_max_sig) begin
        w_max_sig  = r_sig[i];
        w_max_slot = LOG_COMPARATORS'(i);
      end
    end
  end

  // An all-ones beat can never be strictly below the maximum, so it is never stored.
  assign w_do_insert = i_ins_valid && (i_ins_sig < w_max_sig);

  // Slot storage: sentinel on reset/clear, otherwise overwrite the max slot on insert.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_COMPARATORS; i++) begin
        r_sig[i] <= '1;
        r_idx[i] <= '0;
      end
    end else if (i_clear) begin
      for (int i = 0; i < NUM_COMPARATORS; i++) begin
        r_sig[i] <= '1;
        r_idx[i] <= '0;
      end
    end else if (w_do_insert) begin
      r_sig[w_max_slot] <= i_ins_sig;
      r_idx[w_max_slot] <= i_ins_idx;
    end
  end

  assign o_rd_sig = r_sig[i_rd_slot];
  assign o_rd_idx = r_idx[i_rd_slot];

endmodule

// File: rtl/minhash_sketch_ctrl.sv
// MinHash sketch controller: accepts a stream of k-mer (signature, index)
// beats, keeps the NUM_COMPARATORS smallest signatures, then reads the
// sketch out slot by slot and clears the store for the next sequence.
//
// Handshake: a beat moves on a port in any cycle where valid && ready are
// both high at the rising edge. in_ready is high only in ACCEPT; out_valid
// is high only in READOUT, and out_* hold steady until out_ready accepts.
module minhash_sketch_ctrl
  import minhash_pkg::*;
#(
  parameter int SIGNATURE_WIDTH = SIGNATURE_WIDTH_DEF,
  parameter int INDEX_WIDTH     = INDEX_WIDTH_DEF,
  parameter int NUM_COMPARATORS = NUM_COMPARATORS_DEF,
  parameter int LOG_COMPARATORS = LOG_COMPARATORS_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [SIGNATURE_WIDTH-1:0] in_signature,
  input  logic [INDEX_WIDTH-1:0]     in_index,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [SIGNATURE_WIDTH-1:0] out_signature,
  output logic [INDEX_WIDTH-1:0]     out_index,
  output logic [LOG_COMPARATORS-1:0] out_slot,
  output logic                       out_last,
  output logic [15:0]                sketch_count,
  output logic [1:0]                 dbg_state
);

  state_t                     r_state;
  logic                       r_in_ready;
  logic                       r_out_valid;
  logic [LOG_COMPARATORS-1:0] r_slot;
  logic [15:0]                r_count;

  logic                       r_ins_valid;
  logic [SIGNATURE_WIDTH-1:0] r_ins_sig;
  logic [INDEX_WIDTH-1:0]     r_ins_idx;

  logic                       w_in_fire;
  logic                       w_out_fire;
  logic                       w_last_slot;
  logic [SIGNATURE_WIDTH-1:0] w_rd_sig;
  logic [INDEX_WIDTH-1:0]     w_rd_idx;

  assign w_in_fire   = in_valid && r_in_ready;
  assign w_out_fire  = r_out_valid && out_ready;
  assign w_last_slot = (r_slot == LOG_COMPARATORS'(NUM_COMPARATORS - 1));

  // Insert register: captures each accepted beat so the store applies it one edge later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ins_valid <= 1'b0;
      r_ins_sig   <= '0;
      r_ins_idx   <= '0;
    end else begin
      r_ins_valid <= w_in_fire;
      if (w_in_fire) begin
        r_ins_sig <= in_signature;
        r_ins_idx <= in_index;
      end
    end
  end

  minhash_topk_store #(
    .SIGNATURE_WIDTH (SIGNATURE_WIDTH),
    .INDEX_WIDTH     (INDEX_WIDTH),
    .NUM_COMPARATORS (NUM_COMPARATORS),
    .LOG_COMPARATORS (LOG_COMPARATORS)
  ) u_store (
    .clk         (clk),
    .rst         (rst),
    .i_ins_valid (r_ins_valid),
    .i_ins_sig   (r_ins_sig),
    .i_ins_idx   (r_ins_idx),
    .i_clear     (r_state == ST_CLEAR),
    .i_rd_slot   (r_slot),
    .o_rd_sig    (w_rd_sig),
    .o_rd_idx    (w_rd_idx)
  );

  // Control FSM: SETTLE gives the last buffered beat one edge to land before readout starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_ACCEPT;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_slot      <= '0;
      r_count     <= '0;
    end else begin
      case (r_state)
        ST_ACCEPT: begin
          if (w_in_fire && in_last) begin
            r_state    <= ST_SETTLE;
            r_in_ready <= 1'b0;
          end
        end
        ST_SETTLE: begin
          r_state     <= ST_READOUT;
          r_out_valid <= 1'b1;
        end
        ST_READOUT: begin
          if (w_out_fire) begin
            if (w_last_slot) begin
              r_state     <= ST_CLEAR;
              r_out_valid <= 1'b0;
              r_slot      <= '0;
              r_count     <= r_count + 16'd1;
            end else begin
              r_slot <= r_slot + LOG_COMPARATORS'(1);
            end
          end
        end
        ST_CLEAR: begin
          r_state    <= ST_ACCEPT;
          r_in_ready <= 1'b1;
        end
        default: begin
          r_state     <= ST_ACCEPT;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_slot      <= '0;
        end
      endcase
    end
  end

  // Readout data comes straight from the store and is zero whenever no beat is offered.
  assign in_ready      = r_in_ready;
  assign out_valid     = r_out_valid;
  assign out_last      = r_out_valid && w_last_slot;
  assign out_slot      = r_slot;
  assign out_signature = r_out_valid ? w_rd_sig : '0;
  assign out_index     = r_out_valid ? w_rd_idx : '0;
  assign sketch_count  = r_count;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_minhash_sketch_ctrl.sv
// Directed bench for minhash_sketch_ctrl: a reference bottom-k model turns
// every completed sequence into expected slot records, which are checked
// against the readout stream in slot order.
module tb_minhash_sketch_ctrl;
  import minhash_pkg::*;

  localparam int SW = 32;
  localparam int IW = 10;
  localparam int N  = 8;
  localparam int LC = 3;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [SW-1:0] in_signature;
  logic [IW-1:0] in_index;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] out_signature;
  logic [IW-1:0] out_index;
  logic [LC-1:0] out_slot;
  logic          out_last;
  logic [15:0]   sketch_count;
  logic [1:0]    dbg_state;

  minhash_sketch_ctrl #(
    .SIGNATURE_WIDTH (SW),
    .INDEX_WIDTH     (IW),
    .NUM_COMPARATORS (N),
    .LOG_COMPARATORS (LC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_signature  (in_signature),
    .in_index      (in_index),
    .in_last       (in_last),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_signature (out_signature),
    .out_index     (out_index),
    .out_slot      (out_slot),
    .out_last      (out_last),
    .sketch_count  (sketch_count),
    .dbg_state     (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state
  int            n_cmp = 0;
  int            n_mis = 0;
  int            exp_slot = 0;
  logic [15:0]   exp_count = '0;
  logic [SW+IW-1:0] exp_q[$];
  logic [SW-1:0] m_sig [N];
  logic [IW-1:0] m_idx [N];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_sig[i] = SENTINEL_SIG;
      m_idx[i] = '0;
    end
  endtask

  task automatic model_insert(input logic [SW-1:0] sig, input logic [IW-1:0] idx);
    int ms;
    ms = 0;
    for (int i = 1; i < N; i++)
      if (m_sig[i] > m_sig[ms]) ms = i;
    if (sig < m_sig[ms]) begin
      m_sig[ms] = sig;
      m_idx[ms] = idx;
    end
  endtask

  // Completed sequence: queue the expected readout, store starts empty again.
  task automatic model_push();
    for (int i = 0; i < N; i++) exp_q.push_back({m_sig[i], m_idx[i]});
    model_clear();
  endtask

  // Driver: called at a falling edge, returns at the falling edge after the transfer.
  task automatic send_beat(input logic [SW-1:0] sig, input logic [IW-1:0] idx, input logic last);
    int t;
    in_valid     = 1'b1;
    in_signature = sig;
    in_index     = idx;
    in_last      = last;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'(1));
    @(negedge clk);
    model_insert(sig, idx);
    if (last) begin
      in_valid = 1'b0;
      in_last  = 1'b0;
      model_push();
      check("settle_out_valid", 64'(out_valid), 64'(0));
      check("settle_in_ready", 64'(in_ready), 64'(0));
      @(negedge clk);
      check("out_valid_latency", 64'(out_valid), 64'(1));
    end
  endtask

  // Consume one readout beat, optionally holding out_ready low for a while first.
  task automatic read_beat(input int stall);
    logic [SW+IW-1:0] e;
    int t;
    t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid) check("out_valid_timeout", 64'(out_valid), 64'(1));
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else begin
      check("exp_q_underflow", 64'(exp_q.size()), 64'(1));
      e = '0;
    end
    check("out_slot", 64'(out_slot), 64'(exp_slot));
    check("out_signature", 64'(out_signature), 64'(e[SW+IW-1:IW]));
    check("out_index", 64'(out_index), 64'(e[IW-1:0]));
    check("out_last", 64'(out_last), 64'(exp_slot == N - 1));
    if (stall > 0) begin
      out_ready    = 1'b0;
      // Junk offered outside ACCEPT must be ignored.
      in_valid     = 1'b1;
      in_signature = '0;
      in_index     = '1;
      in_last      = 1'b1;
      repeat (stall) begin
        @(negedge clk);
        check("stall_valid", 64'(out_valid), 64'(1));
        check("stall_slot", 64'(out_slot), 64'(exp_slot));
        check("stall_signature", 64'(out_signature), 64'(e[SW+IW-1:IW]));
        check("stall_index", 64'(out_index), 64'(e[IW-1:0]));
        check("stall_in_ready", 64'(in_ready), 64'(0));
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    if (exp_slot == N - 1) begin
      exp_count = exp_count + 16'd1;
      check("sketch_count", 64'(sketch_count), 64'(exp_count));
      check("clear_out_valid", 64'(out_valid), 64'(0));
    end
    exp_slot = (exp_slot + 1) % N;
  endtask

  task automatic read_sketch(input int stall_slot, input int stall_cycles);
    for (int s = 0; s < N; s++) read_beat((s == stall_slot) ? stall_cycles : 0);
  endtask

  task automatic bench_reset_state();
    exp_q.delete();
    model_clear();
    exp_count = '0;
    exp_slot  = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bench_reset_state();
    @(negedge clk);
  endtask

  initial begin
    rst          = 1'b1;
    in_valid     = 1'b0;
    in_signature = '0;
    in_index     = '0;
    in_last      = 1'b0;
    out_ready    = 1'b0;
    bench_reset_state();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_last", 64'(out_last), 64'(0));
    check("rst_out_signature", 64'(out_signature), 64'(0));
    check("rst_out_index", 64'(out_index), 64'(0));
    check("rst_out_slot", 64'(out_slot), 64'(0));
    check("rst_sketch_count", 64'(sketch_count), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(ST_ACCEPT));

    // Descending 80..10, exactly fills the sketch
    for (int i = 0; i < 8; i++) send_beat(SW'(80 - 10 * i), IW'(i + 1), i == 7);
    read_sketch(-1, 0);

    // 12 back-to-back descending beats, the smaller four displace the largest
    for (int i = 0; i < 12; i++) send_beat(SW'(12 - i), IW'(i), i == 11);
    read_sketch(-1, 0);

    // Duplicates plus an all-ones beat, six slots stay empty
    send_beat(SW'(5), IW'(3), 1'b0);
    send_beat(SW'(5), IW'(9), 1'b0);
    send_beat('1, IW'(2), 1'b1);
    read_sketch(-1, 0);

    // Random sketch with downstream backpressure at slot 3
    for (int i = 0; i < 10; i++) send_beat(SW'($urandom_range(1000, 1)), IW'(i), i == 9);
    read_sketch(3, 5);

    // Reset in the middle of a readout at slot 4
    for (int i = 0; i < 8; i++) send_beat(SW'($urandom_range(5000, 1)), IW'(i + 20), i == 7);
    for (int s = 0; s < 4; s++) read_beat(0);
    check("pre_rst_slot", 64'(out_slot), 64'(4));
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_out_last", 64'(out_last), 64'(0));
    check("midrst_out_signature", 64'(out_signature), 64'(0));
    check("midrst_sketch_count", 64'(sketch_count), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    bench_reset_state();
    @(negedge clk);
    check("postrst_in_ready", 64'(in_ready), 64'(1));
    check("postrst_out_valid", 64'(out_valid), 64'(0));
    check("postrst_sketch_count", 64'(sketch_count), 64'(0));
    // Store must be all sentinel: a single all-ones beat reads back eight empty slots
    send_beat('1, IW'(7), 1'b1);
    read_sketch(-1, 0);

    // Two consecutive sketches from a fresh reset
    do_reset();
    for (int i = 0; i < 8; i++) send_beat(SW'(i + 1), IW'(i), i == 7);
    read_sketch(-1, 0);
    for (int i = 0; i < 8; i++) send_beat(SW'(100 + i), IW'(i + 8), i == 7);
    read_sketch(-1, 0);
    repeat (2) @(negedge clk);
    check("two_sketch_count", 64'(sketch_count), 64'(2));
    check("final_in_ready", 64'(in_ready), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
